// File: rtl/ddma_flit_streamer.sv
// Transmit engine of the per-PE distributed DMA: reads a packet out of local memory
// through a 2-entry flit FIFO and streams it to the router local port under credit control.
module ddma_flit_streamer #(
  parameter int FLIT_WIDTH     = 16,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int NBYTES_WIDTH   = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_in,
  input  logic [MEM_ADDR_WIDTH-1:0] addr_in,
  input  logic [NBYTES_WIDTH-1:0]   nbytes_in,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      rejected_out,
  output logic                      mem_en_out,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [FLIT_WIDTH-1:0]     mem_data_in,
  output logic                      tx_out,
  output logic [FLIT_WIDTH-1:0]     flit_out,
  input  logic                      credit_in
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ZERO = {MEM_ADDR_WIDTH{1'b0}};
  localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE  = {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NBYTES_WIDTH-1:0]   NB_ZERO   = {NBYTES_WIDTH{1'b0}};
  localparam logic [NBYTES_WIDTH-1:0]   NB_ONE    = {{(NBYTES_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [FLIT_WIDTH-1:0]     FLIT_ZERO = {FLIT_WIDTH{1'b0}};

  state_t                    state_r;
  state_t                    state_s;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr_r;
  logic [NBYTES_WIDTH-1:0]   rd_left_r;
  logic [NBYTES_WIDTH-1:0]   tx_left_r;
  logic                      outst_r;
  logic [1:0]                count_r;
  logic [1:0]                count_s;
  logic [FLIT_WIDTH-1:0]     head_r;
  logic [FLIT_WIDTH-1:0]     head_s;
  logic [FLIT_WIDTH-1:0]     tail_r;
  logic [FLIT_WIDTH-1:0]     tail_s;
  logic                      rejected_r;

  logic                      pop_s;
  logic                      push_s;
  logic [2:0]                occ_s;
  logic                      issue_s;
  logic                      accept_s;
  logic                      reject_s;
  logic                      last_pop_s;

  // A pop frees its slot in the same cycle, so a read may be issued against it;
  // this keeps one flit per cycle flowing with only two FIFO entries.
  assign pop_s      = (count_r != 2'd0) & credit_in;
  assign push_s     = outst_r;
  assign occ_s      = {1'b0, count_r} + {2'b00, outst_r} - {2'b00, pop_s};
  assign issue_s    = (state_r == ST_RUN) & (rd_left_r != NB_ZERO) & (occ_s < 3'd2);
  assign last_pop_s = pop_s & (tx_left_r == NB_ONE);
  assign reject_s   = cmd_in & (state_r != ST_IDLE);

  // Next-state and command-accept decode
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_in) begin
          accept_s = 1'b1;
          if (nbytes_in == NB_ZERO) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_pop_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // FIFO next contents: push takes returning read data, pop shifts tail to head
  always_comb begin
    head_s  = head_r;
    tail_s  = tail_r;
    count_s = count_r;
    case ({push_s, pop_s})
      2'b10: begin
        if (count_r == 2'd0) begin
          head_s = mem_data_in;
        end else begin
          tail_s = mem_data_in;
        end
        count_s = count_r + 2'd1;
      end
      2'b01: begin
        head_s  = tail_r;
        count_s = count_r - 2'd1;
      end
      2'b11: begin
        if (count_r == 2'd1) begin
          head_s = mem_data_in;
        end else begin
          head_s = tail_r;
          tail_s = mem_data_in;
        end
      end
      default: begin
        head_s  = head_r;
        tail_s  = tail_r;
        count_s = count_r;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Read-side address/count and in-flight read tracking
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_addr_r <= ADDR_ZERO;
      rd_left_r <= NB_ZERO;
      outst_r   <= 1'b0;
    end else begin
      outst_r <= issue_s;
      if (accept_s) begin
        rd_addr_r <= addr_in;
        rd_left_r <= nbytes_in;
      end else if (issue_s) begin
        rd_addr_r <= rd_addr_r + ADDR_ONE;
        rd_left_r <= rd_left_r - NB_ONE;
      end
    end
  end

  // Flits still to be accepted by the router
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_left_r <= NB_ZERO;
    end else if (accept_s) begin
      tx_left_r <= nbytes_in;
    end else if (pop_s) begin
      tx_left_r <= tx_left_r - NB_ONE;
    end
  end

  // FIFO storage and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_r  <= FLIT_ZERO;
      tail_r  <= FLIT_ZERO;
      count_r <= 2'd0;
    end else begin
      head_r  <= head_s;
      tail_r  <= tail_s;
      count_r <= count_s;
    end
  end

  // Rejected-command pulse, one cycle after the offending cmd_in
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rejected_r <= 1'b0;
    end else begin
      rejected_r <= reject_s;
    end
  end

  assign busy_out     = (state_r == ST_RUN);
  assign done_out     = (state_r == ST_DONE);
  assign rejected_out = rejected_r;
  assign mem_en_out   = issue_s;
  assign mem_addr_out = rd_addr_r;
  assign tx_out       = (count_r != 2'd0);
  assign flit_out     = head_r;

endmodule

// File: tb/tb_ddma_flit_streamer.sv
// Bench for ddma_flit_streamer: memory model, packet-level expected-flit model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_ddma_flit_streamer;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_in;
  logic [15:0] addr_in;
  logic [15:0] nbytes_in;
  logic        busy_out, done_out, rejected_out, mem_en_out, tx_out, credit_in;
  logic [15:0] mem_addr_out, mem_data_in, flit_out;

  ddma_flit_streamer #(.FLIT_WIDTH(16), .MEM_ADDR_WIDTH(16), .NBYTES_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .cmd_in(cmd_in), .addr_in(addr_in), .nbytes_in(nbytes_in),
    .busy_out(busy_out), .done_out(done_out), .rejected_out(rejected_out),
    .mem_en_out(mem_en_out), .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in),
    .tx_out(tx_out), .flit_out(flit_out), .credit_in(credit_in)
  );

  always #5 clock = ~clock;

  int cmp = 0;
  int mism = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // synchronous-read memory: data valid the cycle after mem_en_out
  logic [15:0] mem [0:65535];
  logic [15:0] mem_rdata = 16'h0000;
  always @(posedge clock) if (mem_en_out) mem_rdata <= mem[mem_addr_out];
  assign mem_data_in = mem_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // packet-level model and observation log
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          tcyc_q[$];
  logic [15:0] addr_q[$];
  int          n_done = 0;
  int          n_rej = 0;
  int          done_cyc = 0;
  bit          m_active = 0, m_busy = 0, exp_done = 0, exp_rej = 0, hold_v = 0;
  logic [15:0] hold_f = 16'h0000;

  always @(negedge clock) begin
    bit nd, nr;
    if (reset) begin
      exp_q.delete();
      m_active = 0; m_busy = 0; exp_done = 0; exp_rej = 0; hold_v = 0;
    end else begin
      chk("done_out", done_out, exp_done);
      chk("rejected_out", rejected_out, exp_rej);
      chk("busy_out", busy_out, m_busy);
      if (hold_v) begin
        chk("hold_tx", tx_out, 1);
        chk("hold_flit", flit_out, hold_f);
      end
      if (done_out) begin n_done++; done_cyc = cyc; end
      if (rejected_out) n_rej++;
      if (mem_en_out) addr_q.push_back(mem_addr_out);
      nd = 0; nr = 0;
      if (tx_out && credit_in) begin
        got_q.push_back(flit_out);
        tcyc_q.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_flit", tx_out, 0);
        else begin
          chk("flit_out", flit_out, exp_q.pop_front());
          if (exp_q.size() == 0) begin nd = 1; m_busy = 0; end
        end
      end
      if (cmd_in) begin
        if (!m_active) begin
          m_active = 1;
          for (int i = 0; i < int'(nbytes_in); i++) exp_q.push_back(mem[addr_in + i[15:0]]);
          if (nbytes_in == 16'd0) nd = 1;
          else m_busy = 1;
        end else nr = 1;
      end
      if (exp_done) m_active = 0;
      exp_done = nd;
      exp_rej  = nr;
      hold_v   = tx_out && !credit_in;
      hold_f   = flit_out;
    end
  end

  int cmd_cyc = 0;
  task automatic send_cmd(input logic [15:0] a, input logic [15:0] n);
    @(posedge clock); #1;
    cmd_in = 1'b1; addr_in = a; nbytes_in = n; cmd_cyc = cyc + 1;
    @(posedge clock); #1;
    cmd_in = 1'b0;
  endtask

  task automatic wait_done(input int bd, input int budget);
    int t = 0;
    while (n_done == bd && t < budget) begin @(posedge clock); t++; end
    chk("done_seen", n_done - bd, 1);
  endtask

  task automatic wait_flits(input int b, input int n);
    int t = 0;
    while (got_q.size() - b < n && t < 200) begin @(posedge clock); t++; end
    chk("flits_reached", (got_q.size() - b >= n) ? 1 : 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_done"}, done_out, 0);
    chk({tag, "_rej"}, rejected_out, 0);
    chk({tag, "_memen"}, mem_en_out, 0);
    chk({tag, "_memaddr"}, mem_addr_out, 0);
    chk({tag, "_tx"}, tx_out, 0);
    chk({tag, "_flit"}, flit_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, bd, br, ba;
    reset = 1'b1; cmd_in = 1'b0; addr_in = 16'h0000; nbytes_in = 16'h0000; credit_in = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = i[15:0];
    mem[0] = 16'h0011; mem[1] = 16'h000E;
    mem[16'hFFFE] = 16'hA1B2; mem[16'hFFFF] = 16'hC3D4;
    for (int i = 0; i < 6; i++) mem[16'h0100 + i[15:0]] = 16'h5A00 + i[15:0];
    repeat (3) @(posedge clock); #1;
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // T1: 16-flit packet, full credit
    b = got_q.size(); bd = n_done;
    send_cmd(16'h0000, 16'd16);
    wait_done(bd, 200);
    chk("t1_count", got_q.size() - b, 16);
    chk("t1_f0", got_q[b], 16'h0011);
    chk("t1_f1", got_q[b+1], 16'h000E);
    chk("t1_f2", got_q[b+2], 16'h0002);
    chk("t1_f15", got_q[b+15], 16'h000F);
    chk("t1_first_lat", tcyc_q[b] - cmd_cyc, 2);
    chk("t1_back_to_back", tcyc_q[b+15] - tcyc_q[b], 15);
    chk("t1_done_lat", done_cyc - tcyc_q[b+15], 1);
    repeat (2) @(posedge clock);

    // T2: credit withheld for 5 cycles after the 3rd flit
    b = got_q.size(); bd = n_done;
    send_cmd(16'h0000, 16'd16);
    wait_flits(b, 3);
    #1 credit_in = 1'b0;
    repeat (5) begin
      @(negedge clock);
      chk("t2_stall_memen", mem_en_out, 0);
      chk("t2_stall_tx", tx_out, 1);
      chk("t2_stall_flit", flit_out, 16'h0003);
    end
    @(posedge clock); #1 credit_in = 1'b1;
    wait_done(bd, 200);
    chk("t2_count", got_q.size() - b, 16);
    chk("t2_f3", got_q[b+3], 16'h0003);
    chk("t2_f15", got_q[b+15], 16'h000F);
    repeat (2) @(posedge clock);

    // T3: second command while busy is rejected
    b = got_q.size(); bd = n_done; br = n_rej;
    send_cmd(16'h0000, 16'd8);
    send_cmd(16'h0004, 16'd3);
    wait_done(bd, 200);
    repeat (4) @(posedge clock);
    chk("t3_rejects", n_rej - br, 1);
    chk("t3_dones", n_done - bd, 1);
    chk("t3_count", got_q.size() - b, 8);
    chk("t3_f7", got_q[b+7], 16'h0007);

    // T4: zero-length command
    b = got_q.size(); bd = n_done; ba = addr_q.size();
    send_cmd(16'h0005, 16'd0);
    @(negedge clock);
    chk("t4_done_pulse", done_out, 1);
    chk("t4_busy_in_done", busy_out, 0);
    @(negedge clock);
    chk("t4_done_low", done_out, 0);
    chk("t4_busy_low", busy_out, 0);
    @(posedge clock);
    chk("t4_no_reads", addr_q.size() - ba, 0);
    chk("t4_no_flits", got_q.size() - b, 0);
    chk("t4_dones", n_done - bd, 1);
    chk("t4_done_cycle", done_cyc - cmd_cyc, 0);

    // T5: address wrap
    b = got_q.size(); bd = n_done; ba = addr_q.size();
    send_cmd(16'hFFFE, 16'd4);
    wait_done(bd, 200);
    chk("t5_nreads", addr_q.size() - ba, 4);
    chk("t5_a0", addr_q[ba], 16'hFFFE);
    chk("t5_a1", addr_q[ba+1], 16'hFFFF);
    chk("t5_a2", addr_q[ba+2], 16'h0000);
    chk("t5_a3", addr_q[ba+3], 16'h0001);
    chk("t5_f0", got_q[b], 16'hA1B2);
    chk("t5_f1", got_q[b+1], 16'hC3D4);
    chk("t5_f2", got_q[b+2], 16'h0011);
    chk("t5_f3", got_q[b+3], 16'h000E);
    repeat (2) @(posedge clock);

    // T6: reset mid-transfer, then a fresh packet
    b = got_q.size(); bd = n_done;
    send_cmd(16'h0000, 16'd16);
    wait_flits(b, 5);
    @(negedge clock); #2 reset = 1'b1;
    #1 chk_all_zero("t6_async");
    repeat (2) @(posedge clock); #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    chk("t6_no_done", n_done - bd, 0);
    b = got_q.size(); bd = n_done;
    send_cmd(16'h0100, 16'd6);
    wait_done(bd, 200);
    repeat (2) @(posedge clock);
    chk("t6_count", got_q.size() - b, 6);
    chk("t6_f0", got_q[b], 16'h5A00);
    chk("t6_f5", got_q[b+5], 16'h5A05);
    chk("t6_dones", n_done - bd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end

endmodule
